// File: rtl/pcs66_pkg.sv
// rtl/pcs66_pkg.sv - shared types and constants for the 64b/66b PCS transmit scheduler
package pcs66_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    PAUSE    = 2'd2
  } state_t;

  localparam logic [1:0] SYNC_DATA  = 2'b01;
  localparam logic [1:0] SYNC_CTRL  = 2'b10;
  localparam int         SCR_W      = 58;
  localparam logic [7:0] IDLE_BLOCK = 8'h1E;

  // Only 01 and 10 are legal sync headers; 00 and 11 flag a malformed block.
  function automatic logic hdr_is_bad(input logic [1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

endpackage

// File: rtl/scr58_core.sv
// rtl/scr58_core.sv - x^58+x^39+1 self-synchronising payload scrambler, 64 bits per block
module scr58_core
  import pcs66_pkg::*;
#(
  parameter logic [SCR_W-1:0] SEED = '0
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SCR_W-1:0] seed_val,
  input  logic             advance,
  input  logic             bypass,
  input  logic [63:0]      din,
  output logic [63:0]      dout
);

  logic [SCR_W-1:0] s;
  logic [38:0]      scr_lo;
  logic [18:0]      scr_mid;
  logic [5:0]       scr_hi;

  // Bits 0..38 tap only the previous block; upper bits also feed back from this block's low bits.
  assign scr_lo  = din[38:0]  ^ s[57:19]      ^ s[38:0];
  assign scr_mid = din[57:39] ^ scr_lo[18:0]  ^ s[57:39];
  assign scr_hi  = din[63:58] ^ scr_lo[24:19] ^ scr_lo[5:0];

  assign dout = bypass ? din : {scr_hi, scr_mid, scr_lo};

  // State is the last 58 scrambled bits; it keeps running even when the output is bypassed.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      s <= SEED;
    end else if (load) begin
      s <= seed_val;
    end else if (advance) begin
      s <= {scr_hi, scr_mid, scr_lo[38:6]};
    end
  end

endmodule

// File: rtl/pcs66_tx_sched.sv
// rtl/pcs66_tx_sched.sv - 64b/66b lane transmit scheduler with idle insertion and gearbox pause slots
module pcs66_tx_sched
  import pcs66_pkg::*;
#(
  parameter int               PAUSE_PERIOD = 32,
  parameter logic [63:0]      IDLE_PAYLOAD = {56'h0, IDLE_BLOCK},
  parameter logic [SCR_W-1:0] SEED         = '0
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             bypass,
  input  logic             seed_load,
  input  logic [SCR_W-1:0] seed_val,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_hdr,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  output logic [1:0]       out_hdr,
  output logic [63:0]      out_data,
  output logic             idle_ins,
  output logic [15:0]      blk_cnt,
  output logic             err_hdr
);

  localparam int             PCW       = $clog2(PAUSE_PERIOD);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PAUSE_PERIOD - 1);

  state_t         state;
  logic [PCW-1:0] pcnt;
  logic           bypass_q;
  logic           emit;
  logic [1:0]     blk_hdr;
  logic [63:0]    blk_data;
  logic [63:0]    scr_dout;

  assign in_ready = (state == RUN);
  assign emit     = (state == RUN) && enable;
  assign blk_hdr  = in_valid ? in_hdr  : SYNC_CTRL;
  assign blk_data = in_valid ? in_data : IDLE_PAYLOAD;

  scr58_core #(
    .SEED (SEED)
  ) u_scr (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .load     (seed_load && (state == DISABLED)),
    .seed_val (seed_val),
    .advance  (emit),
    .bypass   (bypass_q),
    .din      (blk_data),
    .dout     (scr_dout)
  );

  // Lane FSM: one block per RUN cycle, a single idle slot after every PAUSE_PERIOD blocks.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= DISABLED;
      pcnt      <= '0;
      bypass_q  <= 1'b0;
      out_valid <= 1'b0;
      out_hdr   <= 2'b00;
      out_data  <= 64'h0;
      idle_ins  <= 1'b0;
      blk_cnt   <= 16'h0;
      err_hdr   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      idle_ins  <= 1'b0;
      case (state)
        DISABLED: begin
          bypass_q <= bypass;
          if (enable) begin
            state <= RUN;
            pcnt  <= '0;
          end
        end
        RUN: begin
          if (!enable) begin
            state <= DISABLED;
          end else begin
            out_valid <= 1'b1;
            out_hdr   <= blk_hdr;
            out_data  <= scr_dout;
            idle_ins  <= !in_valid;
            blk_cnt   <= blk_cnt + 16'd1;
            if (in_valid && hdr_is_bad(in_hdr)) begin
              err_hdr <= 1'b1;
            end
            if (pcnt == PCNT_LAST) begin
              state <= PAUSE;
              pcnt  <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        PAUSE: begin
          state <= enable ? RUN : DISABLED;
        end
        default: begin
          state <= DISABLED;
        end
      endcase
    end
  end

endmodule
